// File: rtl/shift_seq_pkg.sv
// Shared types for the shift sequencer: FSM states, shift-stage codes, length clamp.
// No logic of its own; the coef helper keeps the reserved NOP code off the shift-stage bus.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] LEFT2 = 2'b00;
  localparam logic [1:0] LEFT4 = 2'b01;
  localparam logic [1:0] RIGHT = 2'b10;
  localparam logic [1:0] NOP   = 2'b11;

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

  function automatic logic [1:0] safe_coef(input logic [1:0] code);
    case (code)
      LEFT2, LEFT4, RIGHT: return code;
      default:             return LEFT2;
    endcase
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Job request, shift-stage and result signals of the shift sequencer.
// start_valid/start_ready handshake; sh_result is a combinational return from the shift stage.
interface shift_seq_ctrl_if #(
  parameter int SIZE  = 5,
  parameter int STEPS = 4,
  parameter int ACC_W = SIZE + 3
);
  localparam int LEN_W = $clog2(STEPS + 1);

  logic               start_valid;
  logic               start_ready;
  logic [SIZE-1:0]    op_in;
  logic [2*STEPS-1:0] cmd_in;
  logic [LEN_W-1:0]   len_in;
  logic [SIZE-1:0]    sh_data;
  logic [1:0]         sh_coef;
  logic [SIZE-1:0]    sh_result;
  logic [ACC_W-1:0]   acc_out;
  logic               done;
  logic               busy;

  modport master (
    output start_valid, op_in, cmd_in, len_in, sh_result,
    input  start_ready, sh_data, sh_coef, acc_out, done, busy
  );

  modport slave (
    input  start_valid, op_in, cmd_in, len_in, sh_result,
    output start_ready, sh_data, sh_coef, acc_out, done, busy
  );

endinterface

// File: rtl/shift_seq_fsm.sv
// Sequencer control: IDLE/STEP/DONE with step counter; done arrives len+1 cycles after accept.
// start_ready only in IDLE, so requests during STEP/DONE are simply not taken.
module shift_seq_fsm
  import shift_seq_pkg::*;
#(
  parameter int STEPS = 4,
  parameter int LEN_W = $clog2(STEPS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  input  logic [LEN_W-1:0] len_in,
  output logic             accept,
  output logic             step_en,
  output logic             enter_done,
  output logic             done,
  output logic             busy,
  output logic             start_ready
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] len_clamped;

  assign len_clamped = LEN_W'(clamp_len(int'(len_in), STEPS));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          len_d   = len_clamped;
          count_d = '0;
          state_d = (len_clamped == '0) ? DONE : STEP;
        end
      end
      STEP: begin
        count_d = count_q + LEN_W'(1);
        // count_q+1 reaching len marks the final step of the job
        if (count_q + LEN_W'(1) == len_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_ready = (state_q == IDLE);
    accept      = (state_q == IDLE) && start_valid;
    step_en     = (state_q == STEP);
    done        = (state_q == DONE);
    busy        = (state_q == STEP) || (state_q == DONE);
    enter_done  = (state_d == DONE) && (state_q != DONE);
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Iterative scale-and-sum: drives one shift code per cycle, feeds results back, sums them.
// Done pulses len+1 cycles after accept; new jobs are taken only in IDLE.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int SIZE  = 5,
  parameter int STEPS = 4,
  parameter int ACC_W = SIZE + 3
) (
  input logic             clk,
  input logic             rst,
  shift_seq_ctrl_if.slave bus
);

  localparam int LEN_W = $clog2(STEPS + 1);

  logic               accept, step_en, enter_done;
  logic [SIZE-1:0]    work_q, work_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [2*STEPS-1:0] cmd_q, cmd_d;
  logic [ACC_W-1:0]   acc_out_q, acc_out_d;
  logic [1:0]         code;

  shift_seq_fsm #(
    .STEPS (STEPS),
    .LEN_W (LEN_W)
  ) u_fsm (
    .clk         (clk),
    .rst         (rst),
    .start_valid (bus.start_valid),
    .len_in      (bus.len_in),
    .accept      (accept),
    .step_en     (step_en),
    .enter_done  (enter_done),
    .done        (bus.done),
    .busy        (bus.busy),
    .start_ready (bus.start_ready)
  );

  assign code = cmd_q[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      work_q    <= '0;
      acc_q     <= '0;
      cmd_q     <= '0;
      acc_out_q <= '0;
    end else begin
      work_q    <= work_d;
      acc_q     <= acc_d;
      cmd_q     <= cmd_d;
      acc_out_q <= acc_out_d;
    end
  end

  always_comb begin
    work_d    = work_q;
    acc_d     = acc_q;
    cmd_d     = cmd_q;
    acc_out_d = acc_out_q;
    if (accept) begin
      work_d = bus.op_in;
      cmd_d  = bus.cmd_in;
      acc_d  = '0;
    end else if (step_en) begin
      cmd_d = cmd_q >> 2;
      // NOP code leaves operand and sum untouched but still consumes a step
      if (code != NOP) begin
        work_d = bus.sh_result;
        acc_d  = acc_q + ACC_W'(bus.sh_result);
      end
    end
    if (enter_done) acc_out_d = acc_d;
  end

  assign bus.sh_data = step_en ? work_q : '0;
  assign bus.sh_coef = step_en ? safe_coef(code) : LEFT2;
  assign bus.acc_out = acc_out_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: external shift stage, queue-based reference model and monitor.
module tb_shift_seq_ctrl;

  typedef struct {
    int acc;
    int cyc;
  } done_t;

  typedef struct {
    int data;
    int coef;
  } step_t;

  logic  clk;
  logic  rst;
  int    cyc;
  int    checks;
  int    errors;
  int    last_done_exp;
  done_t dq[$];
  step_t sq[$];
  done_t mon_d;
  step_t mon_s;

  shift_seq_ctrl_if #(.SIZE(5), .STEPS(4), .ACC_W(8)) bus ();

  shift_seq_ctrl #(.SIZE(5), .STEPS(4), .ACC_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [4:0] stage(input logic [4:0] d, input logic [1:0] c);
    case (c)
      2'b00:   stage = d << 1;
      2'b01:   stage = d << 2;
      2'b10:   stage = d >> 1;
      default: stage = d;
    endcase
  endfunction

  assign bus.sh_result = stage(bus.sh_data, bus.sh_coef);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: expected per-step bus values and final sum, from plain arithmetic.
  task automatic push_job(input int op, input int cmd, input int len, input int acc_cyc);
    int    l, w, a, c;
    step_t s;
    done_t d;
    l = (len > 4) ? 4 : len;
    w = op;
    a = 0;
    for (int k = 0; k < l; k++) begin
      c = (cmd >> (2 * k)) & 3;
      s.data = w;
      s.coef = (c == 3) ? 0 : c;
      sq.push_back(s);
      if (c != 3) begin
        if (c == 0) w = (w * 2) % 32;
        else if (c == 1) w = (w * 4) % 32;
        else w = w / 2;
        a = (a + w) % 256;
      end
    end
    d.acc = a;
    d.cyc = acc_cyc + l + 1;
    dq.push_back(d);
    last_done_exp = d.cyc;
  endtask

  task automatic issue(input logic [4:0] op, input logic [7:0] cmd, input logic [2:0] len,
                       input bit hold, input bit b2b);
    bit accepted;
    int n;
    int prev_done;
    prev_done       = last_done_exp;
    bus.op_in       = op;
    bus.cmd_in      = cmd;
    bus.len_in      = len;
    bus.start_valid = 1'b1;
    accepted        = 1'b0;
    n               = 0;
    while (!accepted && n < 200) begin
      @(negedge clk);
      if (bus.start_ready && !rst) begin
        accepted = 1'b1;
        if (b2b) chk("b2b_accept_cycle", cyc, prev_done + 1);
        push_job(int'(op), int'(cmd), int'(len), cyc);
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: start_ready never seen, waited %0d cycles", n);
    end
    if (!hold) bus.start_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_start_ready"}, int'(bus.start_ready), 1);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_acc_out"}, int'(bus.acc_out), 0);
    chk({tag, "_sh_data"}, int'(bus.sh_data), 0);
    chk({tag, "_sh_coef"}, int'(bus.sh_coef), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done) begin
        if (dq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done=1 acc_out=%0d with no job pending", bus.acc_out);
        end else begin
          mon_d = dq.pop_front();
          chk("acc_out", int'(bus.acc_out), mon_d.acc);
          chk("done_cycle", cyc, mon_d.cyc);
        end
      end
      if (bus.busy && !bus.done) begin
        if (sq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_step: busy in step with no step pending, sh_data=%0d", bus.sh_data);
        end else begin
          mon_s = sq.pop_front();
          chk("sh_data", int'(bus.sh_data), mon_s.data);
          chk("sh_coef", int'(bus.sh_coef), mon_s.coef);
        end
      end else begin
        chk("idle_sh_data", int'(bus.sh_data), 0);
        chk("idle_sh_coef", int'(bus.sh_coef), 0);
      end
    end
  end

  initial begin
    bit hold_prev;
    bit hold_now;
    int n;
    checks          = 0;
    errors          = 0;
    last_done_exp   = 0;
    rst             = 1'b1;
    bus.start_valid = 1'b0;
    bus.op_in       = '0;
    bus.cmd_in      = '0;
    bus.len_in      = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1;

    issue(5'd3, 8'b00_10_01_00, 3'd3, 1'b0, 1'b0);
    issue(5'd31, 8'b00_00_00_00, 3'd1, 1'b0, 1'b0);
    issue(5'd7, 8'b11_10_01_01, 3'd0, 1'b0, 1'b0);
    issue(5'd5, 8'b00_00_00_11, 3'd2, 1'b0, 1'b0);

    // Abandon a job in its second step cycle
    issue(5'd9, 8'b11_10_01_00, 3'd4, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    dq.delete();
    sq.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("midjob_reset");
    @(posedge clk);
    #1;
    issue(5'd6, 8'b00_00_10_01, 3'd3, 1'b0, 1'b0);

    // start_valid held through a clamped job and into the next
    issue(5'd17, 8'b01_00_10_00, 3'd7, 1'b1, 1'b0);
    issue(5'd11, 8'b10_01_00_11, 3'd4, 1'b0, 1'b1);

    hold_prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      hold_now = 1'($urandom_range(0, 1));
      issue(5'($urandom_range(0, 31)), 8'($urandom), 3'($urandom_range(0, 7)), hold_now, hold_prev);
      hold_prev = hold_now;
    end
    bus.start_valid = 1'b0;

    n = 0;
    while (dq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("drain_pending_jobs", dq.size(), 0);
    chk("drain_pending_steps", sq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
